except_result: RTL and testbench

Special-result generator for the FPU: the encode-side counterpart of the operand exception unit. It takes an operation code, both raw operands and the per-operand classification flags, then decides whether the IEEE-754 result is a special value (NaN, Inf, signed zero). When it is, the block supplies that value to override the arithmetic datapath and raises the exception flags. It is a 2-stage valid/ready pipeline sitting in parallel with the add/mul/div cores, and it keeps sticky status flags for the FPU status register.

---
 rtl/except_result.sv | 234 +++++++++++++++++++++++
 tb/tb_except_result.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/except_result.sv
// except_result: special-value (NaN/Inf/signed-zero) generator for the FPU result path.
// Latency: two register stages (operand capture, decoded result); throughput 1/cycle.
// Backpressure: out_valid holds its result until out_ready; in_ready = !s1_valid | !s2_valid | out_ready.
// Optional feature: define EXCEPT_NAN_PAYLOAD_EN to propagate NaN sign/payload (else canonical qNaN).
module except_result (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fpu_op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        opa_nan,
  input  logic        opb_nan,
  input  logic        opa_inf,
  input  logic        opb_inf,
  input  logic        opa_00,
  input  logic        opb_00,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        special,
  output logic [31:0] result,
  output logic        invalid,
  output logic        div_zero,
  input  logic        clr_sticky,
  output logic        sticky_invalid,
  output logic        sticky_div_zero,
  output logic        sticky_inf
);

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  // Stage 1: captured request
  logic        s1_valid_q;
  logic [2:0]  s1_op_q;
  logic [31:0] s1_opa_q, s1_opb_q;
  logic        s1_a_nan_q, s1_b_nan_q, s1_a_inf_q, s1_b_inf_q, s1_a_00_q, s1_b_00_q;

  // Stage 2: decoded result
  logic        s2_valid_q;
  logic        s2_special_q, s2_special_d;
  logic [31:0] s2_result_q, s2_result_d;
  logic        s2_invalid_q, s2_invalid_d;
  logic        s2_div_zero_q, s2_div_zero_d;

  logic sticky_invalid_q, sticky_invalid_d;
  logic sticky_div_zero_q, sticky_div_zero_d;
  logic sticky_inf_q, sticky_inf_d;

  logic s2_free;
  logic s1_load;
  logic s2_load;
  logic out_hs;

  // Stage 2 frees up when empty or being drained; stage 1 then frees up behind it.
  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_free;
  assign out_hs   = s2_valid_q && out_ready;

  // Exponent bits never influence the decode (class flags carry that information);
  // payload bits are only consumed when payload propagation is built in.
  logic unused_bits;
  assign unused_bits = ^{s1_opa_q[30:23], s1_opb_q[30:23], s1_opa_q[21:0], s1_opb_q[21:0]};

  // Stage 1 register: capture operands and class flags on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 3'b000;
      s1_opa_q   <= 32'h0;
      s1_opb_q   <= 32'h0;
      s1_a_nan_q <= 1'b0;
      s1_b_nan_q <= 1'b0;
      s1_a_inf_q <= 1'b0;
      s1_b_inf_q <= 1'b0;
      s1_a_00_q  <= 1'b0;
      s1_b_00_q  <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (s1_load) begin
        s1_op_q    <= fpu_op;
        s1_opa_q   <= opa;
        s1_opb_q   <= opb;
        s1_a_nan_q <= opa_nan;
        s1_b_nan_q <= opb_nan;
        s1_a_inf_q <= opa_inf;
        s1_b_inf_q <= opb_inf;
        s1_a_00_q  <= opa_00;
        s1_b_00_q  <= opb_00;
      end
    end
  end

  // Special-result decode from stage 1 contents, first matching rule wins.
  always_comb begin
    logic a_snan, b_snan, sign_x, sign_b_eff;
    logic [31:0] a_quiet, b_quiet;
    s2_special_d  = 1'b0;
    s2_result_d   = 32'h0;
    s2_invalid_d  = 1'b0;
    s2_div_zero_d = 1'b0;
    a_snan     = s1_a_nan_q && !s1_opa_q[22];
    b_snan     = s1_b_nan_q && !s1_opb_q[22];
    sign_x     = s1_opa_q[31] ^ s1_opb_q[31];
    sign_b_eff = s1_opb_q[31] ^ (s1_op_q == OP_SUB);
    a_quiet    = {s1_opa_q[31], 8'hFF, 1'b1, s1_opa_q[21:0]};
    b_quiet    = {s1_opb_q[31], 8'hFF, 1'b1, s1_opb_q[21:0]};

    if (a_snan || b_snan) begin
      s2_special_d = 1'b1;
      s2_invalid_d = 1'b1;
`ifdef EXCEPT_NAN_PAYLOAD_EN
      s2_result_d  = a_snan ? a_quiet : b_quiet;
`else
      s2_result_d  = QNAN;
`endif
    end else if (s1_a_nan_q || s1_b_nan_q) begin
      s2_special_d = 1'b1;
`ifdef EXCEPT_NAN_PAYLOAD_EN
      s2_result_d  = s1_a_nan_q ? s1_opa_q : s1_opb_q;
`else
      s2_result_d  = QNAN;
`endif
    end else begin
      case (s1_op_q)
        OP_ADD, OP_SUB: begin
          if (s1_a_inf_q && s1_b_inf_q && (s1_opa_q[31] != sign_b_eff)) begin
            s2_special_d = 1'b1;
            s2_invalid_d = 1'b1;
            s2_result_d  = QNAN;
          end else if (s1_a_inf_q) begin
            s2_special_d = 1'b1;
            s2_result_d  = {s1_opa_q[31], INF_MAG};
          end else if (s1_b_inf_q) begin
            s2_special_d = 1'b1;
            s2_result_d  = {sign_b_eff, INF_MAG};
          end
        end
        OP_MUL: begin
          if ((s1_a_inf_q && s1_b_00_q) || (s1_b_inf_q && s1_a_00_q)) begin
            s2_special_d = 1'b1;
            s2_invalid_d = 1'b1;
            s2_result_d  = QNAN;
          end else if (s1_a_inf_q || s1_b_inf_q) begin
            s2_special_d = 1'b1;
            s2_result_d  = {sign_x, INF_MAG};
          end else if (s1_a_00_q || s1_b_00_q) begin
            s2_special_d = 1'b1;
            s2_result_d  = {sign_x, 31'h0};
          end
        end
        OP_DIV: begin
          if ((s1_a_00_q && s1_b_00_q) || (s1_a_inf_q && s1_b_inf_q)) begin
            s2_special_d = 1'b1;
            s2_invalid_d = 1'b1;
            s2_result_d  = QNAN;
          end else if (s1_a_inf_q) begin
            s2_special_d = 1'b1;
            s2_result_d  = {sign_x, INF_MAG};
          end else if (s1_b_00_q) begin
            // a is finite and nonzero here: both other cases were caught above
            s2_special_d  = 1'b1;
            s2_div_zero_d = 1'b1;
            s2_result_d   = {sign_x, INF_MAG};
          end else if (s1_b_inf_q || s1_a_00_q) begin
            s2_special_d = 1'b1;
            s2_result_d  = {sign_x, 31'h0};
          end
        end
        default: begin
          s2_special_d = 1'b0;
        end
      endcase
    end
  end

  // Stage 2 register: advance when the output slot is free, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q    <= 1'b0;
      s2_special_q  <= 1'b0;
      s2_result_q   <= 32'h0;
      s2_invalid_q  <= 1'b0;
      s2_div_zero_q <= 1'b0;
    end else if (s2_free) begin
      s2_valid_q <= s1_valid_q;
      if (s2_load) begin
        s2_special_q  <= s2_special_d;
        s2_result_q   <= s2_result_d;
        s2_invalid_q  <= s2_invalid_d;
        s2_div_zero_q <= s2_div_zero_d;
      end
    end
  end

  // Sticky next state: a handshake setting a flag beats a same-cycle clear.
  always_comb begin
    sticky_invalid_d  = (sticky_invalid_q && !clr_sticky) || (out_hs && s2_invalid_q);
    sticky_div_zero_d = (sticky_div_zero_q && !clr_sticky) || (out_hs && s2_div_zero_q);
    sticky_inf_d      = (sticky_inf_q && !clr_sticky) ||
                        (out_hs && s2_special_q && (s2_result_q[30:0] == INF_MAG));
  end

  // Sticky status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_invalid_q  <= 1'b0;
      sticky_div_zero_q <= 1'b0;
      sticky_inf_q      <= 1'b0;
    end else begin
      sticky_invalid_q  <= sticky_invalid_d;
      sticky_div_zero_q <= sticky_div_zero_d;
      sticky_inf_q      <= sticky_inf_d;
    end
  end

  assign out_valid       = s2_valid_q;
  assign special         = s2_special_q;
  assign result          = s2_result_q;
  assign invalid         = s2_invalid_q;
  assign div_zero        = s2_div_zero_q;
  assign sticky_invalid  = sticky_invalid_q;
  assign sticky_div_zero = sticky_div_zero_q;
  assign sticky_inf      = sticky_inf_q;

endmodule

// File: tb/tb_except_result.sv
// Bench for except_result: directed vectors, expected responses queued at acceptance,
// a negedge monitor pops and compares on each output handshake and checks hold-under-stall.
module tb_except_result;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fpu_op;
  logic [31:0] opa, opb;
  logic        opa_nan, opb_nan, opa_inf, opb_inf, opa_00, opb_00;
  logic        out_valid;
  logic        out_ready;
  logic        special;
  logic [31:0] result;
  logic        invalid, div_zero;
  logic        clr_sticky;
  logic        sticky_invalid, sticky_div_zero, sticky_inf;

  always #5 clk = ~clk;

  except_result dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fpu_op(fpu_op), .opa(opa), .opb(opb),
    .opa_nan(opa_nan), .opb_nan(opb_nan), .opa_inf(opa_inf), .opb_inf(opb_inf),
    .opa_00(opa_00), .opb_00(opb_00),
    .out_valid(out_valid), .out_ready(out_ready), .special(special), .result(result),
    .invalid(invalid), .div_zero(div_zero), .clr_sticky(clr_sticky),
    .sticky_invalid(sticky_invalid), .sticky_div_zero(sticky_div_zero), .sticky_inf(sticky_inf)
  );

  typedef struct packed {
    logic        special;
    logic [31:0] result;
    logic        invalid;
    logic        div_zero;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  localparam logic [31:0] QN = 32'h7FC0_0000;
`ifdef EXCEPT_NAN_PAYLOAD_EN
  localparam logic [31:0] R_SNAN_MUL = 32'h7FC1_0000;
  localparam logic [31:0] R_QNAN_A   = 32'h7FC0_0123;
  localparam logic [31:0] R_SNAN_B   = 32'hFFC0_0005;
`else
  localparam logic [31:0] R_SNAN_MUL = QN;
  localparam logic [31:0] R_QNAN_A   = QN;
  localparam logic [31:0] R_SNAN_B   = QN;
`endif

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Class flags derived from the raw encoding (denormals count as nonzero finite)
  function automatic logic [5:0] classify(input logic [31:0] a, input logic [31:0] b);
    logic an, bn, ai, bi, az, bz;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    az = (a[30:0] == 31'h0);
    bz = (b[30:0] == 31'h0);
    return {an, bn, ai, bi, az, bz};
  endfunction

  // Monitor: compare on every output handshake, and check stability while stalled.
  initial begin
    logic stall_prev;
    logic [34:0] held;
    exp_t e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", {63'h0, out_valid}, 64'h1);
          check("hold_data", {29'h0, special, result, invalid, div_zero}, {29'h0, held});
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got %h want none", {special, result, invalid, div_zero});
          end else begin
            e = sb_q.pop_front();
            check("result", {29'h0, special, result, invalid, div_zero}, {29'h0, e});
          end
        end
        stall_prev = out_valid && !out_ready;
        held = {special, result, invalid, div_zero};
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, queue its expected response.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int n;
    fpu_op = op;
    opa = a;
    opb = b;
    {opa_nan, opb_nan, opa_inf, opb_inf, opa_00, opb_00} = classify(a, b);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) timeout_fail("send_accept");
    else sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (sb_q.size() != 0 || out_valid) timeout_fail("drain");
    @(posedge clk);
    #1;
  endtask

  vec_t vt[] = '{
    '{3'b000, 32'h3F80_0000, 32'h4000_0000, '{1'b0, 32'h0,          1'b0, 1'b0}},
    '{3'b000, 32'h7F80_0000, 32'h3F80_0000, '{1'b1, 32'h7F80_0000, 1'b0, 1'b0}},
    '{3'b001, 32'h3F80_0000, 32'hFF80_0000, '{1'b1, 32'h7F80_0000, 1'b0, 1'b0}},
    '{3'b000, 32'h7F80_0000, 32'h7F80_0000, '{1'b1, 32'h7F80_0000, 1'b0, 1'b0}},
    '{3'b000, 32'hFF80_0000, 32'h7F80_0000, '{1'b1, QN,            1'b1, 1'b0}},
    '{3'b001, 32'h0000_0000, 32'h0000_0000, '{1'b0, 32'h0,          1'b0, 1'b0}},
    '{3'b010, 32'h7F80_0000, 32'h8000_0000, '{1'b1, QN,            1'b1, 1'b0}},
    '{3'b010, 32'hC000_0000, 32'h0000_0000, '{1'b1, 32'h8000_0000, 1'b0, 1'b0}},
    '{3'b010, 32'h7F80_0000, 32'hBF80_0000, '{1'b1, 32'hFF80_0000, 1'b0, 1'b0}},
    '{3'b011, 32'h0000_0000, 32'h8000_0000, '{1'b1, QN,            1'b1, 1'b0}},
    '{3'b011, 32'h7F80_0000, 32'h4000_0000, '{1'b1, 32'h7F80_0000, 1'b0, 1'b0}},
    '{3'b011, 32'h3F80_0000, 32'hFF80_0000, '{1'b1, 32'h8000_0000, 1'b0, 1'b0}},
    '{3'b011, 32'h8000_0000, 32'hC040_0000, '{1'b1, 32'h0000_0000, 1'b0, 1'b0}},
    '{3'b000, 32'h7FC0_0123, 32'h3F80_0000, '{1'b1, R_QNAN_A,      1'b0, 1'b0}},
    '{3'b000, 32'h7FC0_0001, 32'hFF80_0005, '{1'b1, R_SNAN_B,      1'b1, 1'b0}},
    '{3'b100, 32'h7F80_0000, 32'h0000_0000, '{1'b0, 32'h0,          1'b0, 1'b0}},
    '{3'b011, 32'h7F80_0000, 32'h0000_0000, '{1'b1, 32'h7F80_0000, 1'b0, 1'b0}},
    '{3'b111, 32'h7FC0_0000, 32'h3F80_0000, '{1'b1, QN,            1'b0, 1'b0}}
  };

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    fpu_op = 3'b000;
    opa = 32'h0;
    opb = 32'h0;
    {opa_nan, opb_nan, opa_inf, opb_inf, opa_00, opb_00} = 6'h0;
    out_ready = 1'b1;
    clr_sticky = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_outputs", {29'h0, special, result, invalid, div_zero}, 64'h0);
    check("rst_stickies", {61'h0, sticky_invalid, sticky_div_zero, sticky_inf}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Inf - Inf: invalid, out_valid appears on the second edge counting the accepting one
    send(3'b001, 32'h7F80_0000, 32'h7F80_0000, '{1'b1, QN, 1'b1, 1'b0});
    @(negedge clk);
    check("lat_not_early", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
    check("lat_valid", {63'h0, out_valid}, 64'h1);
    drain();

    // SNaN operand to mul
    send(3'b010, 32'h7F81_0000, 32'h7FC0_0001, '{1'b1, R_SNAN_MUL, 1'b1, 1'b0});
    drain();
    check("sticky_dz_before", {63'h0, sticky_div_zero}, 64'h0);
    check("sticky_inf_before", {63'h0, sticky_inf}, 64'h0);

    // -1 / 0: div_zero, -Inf, stickies follow the handshake
    send(3'b011, 32'hBF80_0000, 32'h0000_0000, '{1'b1, 32'hFF80_0000, 1'b0, 1'b1});
    drain();
    check("sticky_dz_set", {63'h0, sticky_div_zero}, 64'h1);
    check("sticky_inf_set", {63'h0, sticky_inf}, 64'h1);
    check("sticky_inv_set", {63'h0, sticky_invalid}, 64'h1);

    // Directed table, streamed back to back
    foreach (vt[i]) send(vt[i].op, vt[i].a, vt[i].b, vt[i].e);
    drain();

    // Four back-to-back requests against a 3-cycle stall
    out_ready = 1'b0;
    fork
      begin
        send(3'b010, 32'h4000_0000, 32'h7F80_0000, '{1'b1, 32'h7F80_0000, 1'b0, 1'b0});
        send(3'b011, 32'hBF80_0000, 32'h8000_0000, '{1'b1, 32'h7F80_0000, 1'b0, 1'b1});
        send(3'b000, 32'h3F80_0000, 32'hBF80_0000, '{1'b0, 32'h0,          1'b0, 1'b0});
        send(3'b011, 32'h0000_0000, 32'h4000_0000, '{1'b1, 32'h0000_0000, 1'b0, 1'b0});
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", {63'h0, in_ready}, 64'h0);
        check("bp_out_valid", {63'h0, out_valid}, 64'h1);
        @(negedge clk);
        check("bp_in_ready_still_low", {63'h0, in_ready}, 64'h0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_all_out", {32'h0, sb_q.size()}, 64'h0);

    // Clear in the same cycle as an invalid handshake: invalid survives, others clear
    check("pre_clr_dz", {63'h0, sticky_div_zero}, 64'h1);
    out_ready = 1'b0;
    send(3'b000, 32'hFF80_0000, 32'h7F80_0000, '{1'b1, QN, 1'b1, 1'b0});
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid) timeout_fail("clr_wait_valid");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    check("clr_sticky_inv", {63'h0, sticky_invalid}, 64'h1);
    check("clr_sticky_dz", {63'h0, sticky_div_zero}, 64'h0);
    check("clr_sticky_inf", {63'h0, sticky_inf}, 64'h0);
    drain();

    // Reset mid-stream while out_valid is high and stage 1 is occupied
    send(3'b010, 32'h7F80_0000, 32'h3F80_0000, '{1'b1, 32'h7F80_0000, 1'b0, 1'b0});
    send(3'b011, 32'hBF80_0000, 32'h0000_0000, '{1'b1, 32'hFF80_0000, 1'b0, 1'b1});
    check("mid_pre_valid", {63'h0, out_valid}, 64'h1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("mid_out_valid", {63'h0, out_valid}, 64'h0);
    check("mid_outputs", {29'h0, special, result, invalid, div_zero}, 64'h0);
    check("mid_stickies", {61'h0, sticky_invalid, sticky_div_zero, sticky_inf}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_in_ready", {63'h0, in_ready}, 64'h1);
    check("mid_no_output", {63'h0, out_valid}, 64'h0);
    @(posedge clk);
    #1;

    // Pipeline works again after reset
    send(3'b010, 32'h7F80_0000, 32'h0000_0000, '{1'b1, QN, 1'b1, 1'b0});
    drain();
    check("post_sticky_inv", {63'h0, sticky_invalid}, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
